// File: rtl/flash_report_framer_if.sv
// Byte stream from the report framer to the MCU link: valid/ready handshake.
`timescale 1ns/1ps
interface flash_report_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/flash_report_framer.sv
// Report framer: turns flash-controller write-address and bad-block requests
// into checksummed byte frames on a valid/ready stream, and stretches the
// write-address acknowledge so the slow controller domain can sample it.
`timescale 1ns/1ps
module flash_report_framer #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         ACK_STRETCH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_writeAddr_Transfer,
    input  logic [23:0]           write_addr_row,
    output logic                  end_writeAddr_Transfer,
    input  logic                  en_bad_block_renew_transfer,
    input  logic [11:0]           bad_block_renew_addr,
    flash_report_framer_if.master tx,
    output logic                  busy,
    output logic [1:0]            ovf,
    input  logic                  clr_ovf
);

    localparam int ACK_W = $clog2(ACK_STRETCH + 1);
    localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_STRETCH);
    localparam logic [ACK_W-1:0] ACK_ONE  = ACK_W'(1);
    localparam logic [ACK_W-1:0] ACK_ZERO = ACK_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_TYPE = 3'd2,
        ST_PAY  = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    // Both frame kinds keep their address zero-extended to 24 bits, so a
    // bad-block frame is the low two bytes of the same byte layout.
    function automatic logic [7:0] type_byte(input logic is_bb);
        logic [7:0] t;
        if (is_bb) begin
            t = 8'h02;
        end else begin
            t = 8'h01;
        end
        return t;
    endfunction

    function automatic logic [7:0] pay_byte(input logic [23:0] addr,
                                            input logic        is_bb,
                                            input logic [1:0]  idx);
        logic [1:0] sel;
        logic [7:0] b;
        sel = idx + {1'b0, is_bb};
        case (sel)
            2'd0:    b = addr[23:16];
            2'd1:    b = addr[15:8];
            2'd2:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Zero high byte of a bad-block address drops out of the XOR, so one
    // formula covers both frame kinds.
    function automatic logic [7:0] chk_byte(input logic [23:0] addr,
                                            input logic        is_bb);
        return type_byte(is_bb) ^ addr[23:16] ^ addr[15:8] ^ addr[7:0];
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             frame_bb_q, frame_bb_d;
    logic [23:0]      frame_addr_q, frame_addr_d;
    logic [2:0]       wa_sync_q, wa_sync_d;
    logic [2:0]       bb_sync_q, bb_sync_d;
    logic             pend_wa_q, pend_wa_d;
    logic             pend_bb_q, pend_bb_d;
    logic [23:0]      hold_wa_q, hold_wa_d;
    logic [11:0]      hold_bb_q, hold_bb_d;
    logic [1:0]       ovf_q, ovf_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;

    logic             accept_s;
    logic             launch_wa_s;
    logic             launch_bb_s;
    logic             wa_done_s;
    logic             wa_edge_s;
    logic             bb_edge_s;
    logic             wa_drop_s;
    logic             bb_drop_s;
    logic [1:0]       last_idx_s;

    assign tx.tx_data             = tx_data_q;
    assign tx.tx_valid            = tx_valid_q;
    assign end_writeAddr_Transfer = ack_q;
    assign busy                   = busy_q;
    assign ovf                    = ovf_q;

    // Frame sequencer: arbitration in IDLE, byte stepping on each handshake.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        byte_cnt_d   = byte_cnt_q;
        frame_bb_d   = frame_bb_q;
        frame_addr_d = frame_addr_q;
        launch_wa_s  = 1'b0;
        launch_bb_s  = 1'b0;
        wa_done_s    = 1'b0;
        accept_s     = tx_valid_q & tx.tx_ready;
        if (frame_bb_q) begin
            last_idx_s = 2'd1;
        end else begin
            last_idx_s = 2'd2;
        end
        case (state_q)
            ST_IDLE: begin
                if (pend_bb_q) begin
                    launch_bb_s  = 1'b1;
                    frame_bb_d   = 1'b1;
                    frame_addr_d = {12'h000, hold_bb_q};
                    state_d      = ST_HDR;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = HEADER;
                end else if (pend_wa_q) begin
                    launch_wa_s  = 1'b1;
                    frame_bb_d   = 1'b0;
                    frame_addr_d = hold_wa_q;
                    state_d      = ST_HDR;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = HEADER;
                end else begin
                    tx_valid_d   = 1'b0;
                end
            end
            ST_HDR: begin
                if (accept_s) begin
                    state_d   = ST_TYPE;
                    tx_data_d = type_byte(frame_bb_q);
                end else begin
                    state_d   = ST_HDR;
                end
            end
            ST_TYPE: begin
                if (accept_s) begin
                    state_d    = ST_PAY;
                    byte_cnt_d = 2'd0;
                    tx_data_d  = pay_byte(frame_addr_q, frame_bb_q, 2'd0);
                end else begin
                    state_d    = ST_TYPE;
                end
            end
            ST_PAY: begin
                if (accept_s) begin
                    if (byte_cnt_q == last_idx_s) begin
                        state_d   = ST_CHK;
                        tx_data_d = chk_byte(frame_addr_q, frame_bb_q);
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = pay_byte(frame_addr_q, frame_bb_q,
                                              byte_cnt_q + 2'd1);
                    end
                end else begin
                    state_d = ST_PAY;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    wa_done_s  = ~frame_bb_q;
                end else begin
                    state_d    = ST_CHK;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    // Request capture, overflow tracking, acknowledge stretch and busy.
    always_comb begin
        wa_sync_d = {wa_sync_q[1:0], en_writeAddr_Transfer};
        bb_sync_d = {bb_sync_q[1:0], en_bad_block_renew_transfer};
        wa_edge_s = wa_sync_q[1] & ~wa_sync_q[2];
        bb_edge_s = bb_sync_q[1] & ~bb_sync_q[2];
        // A pending entry whose frame is launching this cycle is already
        // copied into the frame register, so a new edge is not an overflow.
        wa_drop_s = wa_edge_s & pend_wa_q & ~launch_wa_s;
        bb_drop_s = bb_edge_s & pend_bb_q & ~launch_bb_s;
        pend_wa_d = (pend_wa_q & ~launch_wa_s) | wa_edge_s;
        pend_bb_d = (pend_bb_q & ~launch_bb_s) | bb_edge_s;
        if (wa_edge_s & ~wa_drop_s) begin
            hold_wa_d = write_addr_row;
        end else begin
            hold_wa_d = hold_wa_q;
        end
        if (bb_edge_s & ~bb_drop_s) begin
            hold_bb_d = bad_block_renew_addr;
        end else begin
            hold_bb_d = hold_bb_q;
        end
        if (clr_ovf) begin
            ovf_d = 2'b00;
        end else begin
            ovf_d = ovf_q;
        end
        ovf_d = ovf_d | {bb_drop_s, wa_drop_s};
        if (wa_done_s) begin
            ack_cnt_d = ACK_LOAD;
        end else if (ack_cnt_q != ACK_ZERO) begin
            ack_cnt_d = ack_cnt_q - ACK_ONE;
        end else begin
            ack_cnt_d = ack_cnt_q;
        end
        // Registered copy of (counter != 0) one cycle ahead of the counter.
        ack_d  = wa_done_s | (ack_cnt_q > ACK_ONE);
        busy_d = (state_d != ST_IDLE) | pend_wa_d | pend_bb_d;
    end

    // All state flops; asynchronous reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            byte_cnt_q   <= 2'd0;
            frame_bb_q   <= 1'b0;
            frame_addr_q <= 24'h000000;
            wa_sync_q    <= 3'b000;
            bb_sync_q    <= 3'b000;
            pend_wa_q    <= 1'b0;
            pend_bb_q    <= 1'b0;
            hold_wa_q    <= 24'h000000;
            hold_bb_q    <= 12'h000;
            ovf_q        <= 2'b00;
            ack_cnt_q    <= ACK_ZERO;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_bb_q   <= frame_bb_d;
            frame_addr_q <= frame_addr_d;
            wa_sync_q    <= wa_sync_d;
            bb_sync_q    <= bb_sync_d;
            pend_wa_q    <= pend_wa_d;
            pend_bb_q    <= pend_bb_d;
            hold_wa_q    <= hold_wa_d;
            hold_bb_q    <= hold_bb_d;
            ovf_q        <= ovf_d;
            ack_cnt_q    <= ack_cnt_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_flash_report_framer.sv
// Directed bench for flash_report_framer: frame contents, arbitration,
// backpressure, overflow, acknowledge stretch and mid-frame reset.
`timescale 1ns/1ps
module tb_flash_report_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_wa;
    logic [23:0] wa_row;
    logic        ack;
    logic        en_bb;
    logic [11:0] bb_addr;
    logic        busy;
    logic [1:0]  ovf;
    logic        clr_ovf;

    flash_report_framer_if tx_if ();

    flash_report_framer dut (
        .clk                         (clk),
        .rst                         (rst),
        .en_writeAddr_Transfer       (en_wa),
        .write_addr_row              (wa_row),
        .end_writeAddr_Transfer      (ack),
        .en_bad_block_renew_transfer (en_bb),
        .bad_block_renew_addr        (bb_addr),
        .tx                          (tx_if),
        .busy                        (busy),
        .ovf                         (ovf),
        .clr_ovf                     (clr_ovf)
    );

    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for tx_valid; returns the number of negedges waited.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (tx_if.tx_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " valid"}, {31'd0, tx_if.tx_valid}, 32'd1);
    endtask

    // Checks n consecutive bytes with tx_ready high; bytes are MSB-first.
    task automatic check_frame(input string tag, input logic [47:0] bytes,
                               input int n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s byte%0d", tag, i),
                     {24'd0, tx_if.tx_data}, {24'd0, bytes[47-8*i -: 8]});
            check_eq($sformatf("%s valid%0d", tag, i),
                     {31'd0, tx_if.tx_valid}, 32'd1);
            check_eq($sformatf("%s busy%0d", tag, i), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
    endtask

    // Counts cycles with the acknowledge high over a fixed window.
    task automatic count_ack(output int cnt);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (ack === 1'b1) cnt++;
            @(negedge clk);
        end
    endtask

    int          lat;
    int          cnt;
    int          idx;
    int          cyc;
    logic [3:0]  pat;
    logic [47:0] exp_bp;

    initial begin
        rst              = 1'b1;
        en_wa            = 1'b0;
        wa_row           = 24'h000000;
        en_bb            = 1'b0;
        bb_addr          = 12'h000;
        clr_ovf          = 1'b0;
        tx_if.tx_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst tx_valid", {31'd0, tx_if.tx_valid}, 32'd0);
        check_eq("rst tx_data", {24'd0, tx_if.tx_data}, 32'h00);
        check_eq("rst ack", {31'd0, ack}, 32'd0);
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst ovf", {30'd0, ovf}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write-address report with tx_ready held high.
        wa_row = 24'h123456;
        en_wa  = 1'b1;
        wait_valid("wa", lat);
        check_eq("wa latency", lat, 32'd4);
        check_frame("wa", {8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h71}, 6);
        check_eq("wa idle after", {31'd0, tx_if.tx_valid}, 32'd0);
        check_eq("wa ack rise", {31'd0, ack}, 32'd1);
        en_wa = 1'b0;
        count_ack(cnt);
        check_eq("wa ack width", cnt, 32'd4);

        // Bad-block report: no acknowledge.
        bb_addr = 12'hABC;
        en_bb   = 1'b1;
        wait_valid("bb", lat);
        check_frame("bb", {8'hA5, 8'h02, 8'h0A, 8'hBC, 8'hB4, 8'h00}, 5);
        check_eq("bb idle after", {31'd0, tx_if.tx_valid}, 32'd0);
        en_bb = 1'b0;
        count_ack(cnt);
        check_eq("bb no ack", cnt, 32'd0);

        // Simultaneous requests: bad-block first, one idle, then write-address.
        wa_row  = 24'h000001;
        bb_addr = 12'h005;
        en_wa   = 1'b1;
        en_bb   = 1'b1;
        wait_valid("sim", lat);
        check_frame("sim bb", {8'hA5, 8'h02, 8'h00, 8'h05, 8'h07, 8'h00}, 5);
        check_eq("sim gap valid", {31'd0, tx_if.tx_valid}, 32'd0);
        check_eq("sim gap busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_frame("sim wa", {8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00}, 6);
        check_eq("sim ack", {31'd0, ack}, 32'd1);
        en_wa = 1'b0;
        en_bb = 1'b0;
        count_ack(cnt);
        check_eq("sim ack width", cnt, 32'd4);

        // Backpressure: tx_ready pattern 1,0,0,1 repeating.
        exp_bp         = {8'hA5, 8'h01, 8'hC0, 8'hFF, 8'hEE, 8'hD0};
        pat            = 4'b1001;
        tx_if.tx_ready = 1'b0;
        wa_row         = 24'hC0FFEE;
        en_wa          = 1'b1;
        wait_valid("bp", lat);
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 40) begin
            check_eq($sformatf("bp byte%0d c%0d", idx, cyc),
                     {24'd0, tx_if.tx_data}, {24'd0, exp_bp[47-8*idx -: 8]});
            check_eq("bp valid", {31'd0, tx_if.tx_valid}, 32'd1);
            check_eq("bp early ack", {31'd0, ack}, 32'd0);
            tx_if.tx_ready = pat[cyc % 4];
            if (tx_if.tx_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        tx_if.tx_ready = 1'b1;
        check_eq("bp all bytes", idx, 32'd6);
        check_eq("bp ack", {31'd0, ack}, 32'd1);
        check_eq("bp idle", {31'd0, tx_if.tx_valid}, 32'd0);
        en_wa = 1'b0;
        count_ack(cnt);
        check_eq("bp ack width", cnt, 32'd4);

        // Overflow: two bad-block edges while a write-address frame stalls.
        tx_if.tx_ready = 1'b0;
        wa_row         = 24'h0A0B0C;
        en_wa          = 1'b1;
        wait_valid("ovf", lat);
        bb_addr = 12'h001;
        en_bb   = 1'b1;
        repeat (4) @(negedge clk);
        en_bb = 1'b0;
        repeat (4) @(negedge clk);
        bb_addr = 12'h002;
        en_bb   = 1'b1;
        repeat (4) @(negedge clk);
        en_bb = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("ovf set", {30'd0, ovf}, 32'h2);
        check_eq("ovf stall hdr", {24'd0, tx_if.tx_data}, 32'hA5);
        tx_if.tx_ready = 1'b1;
        check_frame("ovf wa", {8'hA5, 8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0C}, 6);
        check_eq("ovf gap", {31'd0, tx_if.tx_valid}, 32'd0);
        en_wa = 1'b0;
        @(negedge clk);
        check_frame("ovf bb", {8'hA5, 8'h02, 8'h00, 8'h01, 8'h03, 8'h00}, 5);
        check_eq("ovf sticky", {30'd0, ovf}, 32'h2);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check_eq("ovf clear", {30'd0, ovf}, 32'h0);
        repeat (8) @(negedge clk);

        // Reset during PAY byte 2, then a fresh complete frame.
        wa_row = 24'h123456;
        en_wa  = 1'b1;
        wait_valid("rstmid", lat);
        repeat (3) @(negedge clk);
        check_eq("rstmid at pay2", {24'd0, tx_if.tx_data}, 32'h34);
        rst   = 1'b1;
        en_wa = 1'b0;
        #1;
        check_eq("rstmid valid", {31'd0, tx_if.tx_valid}, 32'd0);
        check_eq("rstmid busy", {31'd0, busy}, 32'd0);
        check_eq("rstmid ovf", {30'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_ack(cnt);
        check_eq("rstmid no ack", cnt, 32'd0);
        check_eq("rstmid no frame", {31'd0, tx_if.tx_valid}, 32'd0);
        wa_row = 24'hFEDCBA;
        en_wa  = 1'b1;
        wait_valid("post", lat);
        check_frame("post", {8'hA5, 8'h01, 8'hFE, 8'hDC, 8'hBA, 8'h99}, 6);
        check_eq("post ack", {31'd0, ack}, 32'd1);
        en_wa = 1'b0;
        count_ack(cnt);
        check_eq("post ack width", cnt, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
